// File: rtl/trdb_udma_fifo_if.sv
// Buffered bridge from trace debugger packets to the uDMA RX channel: FWFT FIFO,
// capture/drain control and overflow accounting.
module trdb_udma_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [DATA_WIDTH-1:0]         trdb_packet_i,
  input  logic                          trdb_word_valid_i,
  input  logic                          en_i,
  input  logic                          flush_i,
  input  logic                          clear_stat_i,
  output logic [DATA_WIDTH-1:0]         data_rx_data_o,
  output logic                          data_rx_valid_o,
  input  logic                          data_rx_ready_i,
  output logic [1:0]                    data_rx_datasize_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic [CNT_WIDTH-1:0]          drop_cnt_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DepthCnt = (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0]  DataSize = (DATA_WIDTH == 8)  ? 2'd0 :
                                     (DATA_WIDTH == 16) ? 2'd1 : 2'd2;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];

  logic empty, full, pop, push, drop, capture;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == DepthCnt);
    pop     = !empty && data_rx_ready_i;
    // Re-enabling during DRAIN resumes capture in the same cycle.
    capture = (state_q == StRun) || ((state_q == StDrain) && en_i);
    push    = capture && trdb_word_valid_i && (!full || pop) && !flush_i;
    drop    = capture && trdb_word_valid_i && full && !pop && !flush_i;

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en_i) state_d = StRun;
      StRun:   if (!en_i) state_d = StDrain;
      StDrain: begin
        if (en_i)       state_d = StRun;
        else if (empty) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      cnt_d   = '0;
      state_d = en_i ? StRun : StIdle;
    end

    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clear_stat_i) begin
      // A drop in the clearing cycle survives as the first new event.
      ovf_d  = drop;
      drop_d = drop ? CNT_WIDTH'(1) : '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= trdb_packet_i;
  end

  assign data_rx_valid_o    = !empty;
  assign data_rx_data_o     = empty ? '0 : mem_q[rptr_q];
  assign data_rx_datasize_o = DataSize;
  assign fill_level_o       = cnt_q;
  assign busy_o             = (state_q != StIdle);
  assign overflow_o         = ovf_q;
  assign drop_cnt_o         = drop_q;

endmodule

// File: tb/tb_trdb_udma_fifo_if.sv
// Self-checking bench for trdb_udma_fifo_if: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_trdb_udma_fifo_if;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;
  localparam int          SAT   = (1 << CW) - 1;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [DW-1:0]            pkt;
  logic                     wvalid, en, flush, clr, ready;
  logic [DW-1:0]            rx_data;
  logic                     rx_valid;
  logic [1:0]               rx_size;
  logic [$clog2(DEPTH):0]   fill;
  logic                     busy, ovf;
  logic [CW-1:0]            drop_cnt;

  trdb_udma_fifo_if #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .trdb_packet_i     (pkt),
    .trdb_word_valid_i (wvalid),
    .en_i              (en),
    .flush_i           (flush),
    .clear_stat_i      (clr),
    .data_rx_data_o    (rx_data),
    .data_rx_valid_o   (rx_valid),
    .data_rx_ready_i   (ready),
    .data_rx_datasize_o(rx_size),
    .fill_level_o      (fill),
    .busy_o            (busy),
    .overflow_o        (ovf),
    .drop_cnt_o        (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: words as a queue, mode 0=idle 1=run 2=drain, plain integer counts.
  logic [DW-1:0] q[$];
  int  m_mode = 0;
  int  m_drops = 0;
  bit  m_ovf = 1'b0;

  always @(posedge clk) begin
    bit pop_now, cap, is_full, pushed, dropped;
    if (!rst_n) begin
      q.delete();
      m_mode = 0;
      m_drops = 0;
      m_ovf = 1'b0;
    end else begin
      pop_now = (q.size() > 0) && ready;
      cap     = (m_mode == 1) || (m_mode == 2 && en);
      is_full = (q.size() == DEPTH);
      pushed  = 1'b0;
      dropped = 1'b0;
      if (flush) begin
        q.delete();
        m_mode = en ? 1 : 0;
      end else begin
        pushed  = cap && wvalid && (!is_full || pop_now);
        dropped = cap && wvalid && is_full && !pop_now;
        if (m_mode == 0 && en) m_mode = 1;
        else if (m_mode == 1 && !en) m_mode = 2;
        else if (m_mode == 2) m_mode = en ? 1 : (q.size() == 0 ? 0 : 2);
        if (pop_now) void'(q.pop_front());
        if (pushed) q.push_back(pkt);
      end
      if (clr) begin
        m_ovf   = dropped;
        m_drops = dropped ? 1 : 0;
      end else if (dropped) begin
        m_ovf = 1'b1;
        if (m_drops < SAT) m_drops++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 64'(rx_valid), 64'(q.size() > 0));
      check("data", 64'(rx_data), (q.size() > 0) ? 64'(q[0]) : 64'd0);
      check("fill", 64'(fill), 64'(q.size()));
      check("busy", 64'(busy), 64'(m_mode != 0));
      check("overflow", 64'(ovf), 64'(m_ovf));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
      check("datasize", 64'(rx_size), 64'd2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wvalid = 1'b1;
      pkt    = base + DW'(i);
      step();
    end
    wvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pkt = '0; wvalid = 1'b0; en = 1'b0;
    flush = 1'b0; clr = 1'b0; ready = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    check("rst_fill", 64'(fill), 64'd0);
    check("rst_valid", 64'(rx_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);

    // Streaming at full rate, one cycle latency.
    en = 1'b1;
    step();
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wvalid = 1'b1;
      pkt    = 32'hA0 + 32'(i);
      step();
      check("stream_data", 64'(rx_data), 64'(32'hA0 + 32'(i)));
      check("stream_fill", 64'(fill), 64'd1);
    end
    wvalid = 1'b0;
    step();
    check("stream_empty", 64'(fill), 64'd0);

    // Overfill with back-pressure, then drain in order.
    ready = 1'b0;
    push_words(32'hB0, 10);
    check("ovf_fill", 64'(fill), 64'd8);
    check("ovf_drop", 64'(drop_cnt), 64'd2);
    check("ovf_flag", 64'(ovf), 64'd1);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_order", 64'(rx_data), 64'(32'hB0 + 32'(i)));
      step();
    end
    check("drain_fill", 64'(fill), 64'd0);

    // Push and pop together at full.
    ready = 1'b0;
    push_words(32'hC0, 8);
    wvalid = 1'b1; pkt = 32'hC8; ready = 1'b1;
    step();
    wvalid = 1'b0;
    check("fullpp_fill", 64'(fill), 64'd8);
    check("fullpp_drop", 64'(drop_cnt), 64'd2);
    check("fullpp_head", 64'(rx_data), 64'h000000C1);
    for (int i = 0; i < 8; i++) step();
    check("fullpp_tail_empty", 64'(fill), 64'd0);

    // DRAIN: disabled capture, buffered words still flow out.
    ready = 1'b0;
    push_words(32'hD0, 3);
    en = 1'b0;
    step();
    check("drain_busy", 64'(busy), 64'd1);
    wvalid = 1'b1; pkt = 32'hEE;
    step();
    wvalid = 1'b0;
    check("drain_nopush", 64'(fill), 64'd3);
    check("drain_nodrop", 64'(drop_cnt), 64'd2);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain_data", 64'(rx_data), 64'(32'hD0 + 32'(i)));
      step();
    end
    check("drain_done_fill", 64'(fill), 64'd0);
    step();
    check("drain_idle", 64'(busy), 64'd0);

    // Flush wins over a concurrent push.
    en = 1'b1; ready = 1'b0;
    step();
    push_words(32'hE0, 5);
    check("preflush_fill", 64'(fill), 64'd5);
    wvalid = 1'b1; pkt = 32'hFF; flush = 1'b1;
    step();
    wvalid = 1'b0; flush = 1'b0;
    check("flush_fill", 64'(fill), 64'd0);
    check("flush_valid", 64'(rx_valid), 64'd0);
    check("flush_drop", 64'(drop_cnt), 64'd2);
    check("flush_busy", 64'(busy), 64'd1);

    // Saturation and clear concurrent with a drop.
    push_words(32'h100, 8 + 20);
    check("sat_drop", 64'(drop_cnt), 64'hF);
    check("sat_ovf", 64'(ovf), 64'd1);
    wvalid = 1'b1; pkt = 32'h200; clr = 1'b1;
    step();
    wvalid = 1'b0;
    check("clrdrop_cnt", 64'(drop_cnt), 64'd1);
    check("clrdrop_ovf", 64'(ovf), 64'd1);
    step();
    clr = 1'b0;
    check("clr_cnt", 64'(drop_cnt), 64'd0);
    check("clr_ovf", 64'(ovf), 64'd0);

    // Reset mid-operation with a full FIFO.
    check("prerst_fill", 64'(fill), 64'd8);
    rst_n = 1'b0;
    step();
    check("midrst_fill", 64'(fill), 64'd0);
    check("midrst_valid", 64'(rx_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1; en = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
